// File: rtl/demux_8x32_ctrl.sv
// Lane controller for the 8-to-32 demux on the clk_4f domain.
// Finds word alignment from a run of COM characters, then tags payload bytes
// with their lane index and strobes each completed 32-bit word. A COM that
// lands mid-word drops the partial word; enough of those in a row drop lock.
module demux_8x32_ctrl #(
  parameter logic [7:0] COM_CHAR = 8'hBC,
  parameter int unsigned COM_LOCK = 4,   // 1..15
  parameter int unsigned ERR_MAX  = 2    // 1..15
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic [7:0] data_in_8x32,
  input  logic       valid_in_8x32,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] byte_idx,
  output logic       word_done,
  output logic       discard,
  output logic       err_align,
  output logic       active,
  output logic [7:0] word_count
);

  typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [4:0] LOCK_N = 5'(COM_LOCK);
  localparam logic [4:0] ERR_N  = 5'(ERR_MAX);

  state_e     state_q;
  logic [3:0] com_cnt_q;
  logic [1:0] idx_q;
  logic [3:0] err_cnt_q;

  logic [7:0] byte_out_q;
  logic       byte_valid_q;
  logic [1:0] byte_idx_q;
  logic       word_done_q;
  logic       discard_q;
  logic       err_align_q;
  logic [7:0] word_count_q;

  logic       is_com;
  logic [4:0] com_cnt_d;
  logic [4:0] err_cnt_d;

  assign is_com    = (data_in_8x32 == COM_CHAR);
  assign com_cnt_d = {1'b0, com_cnt_q} + 5'd1;
  assign err_cnt_d = {1'b0, err_cnt_q} + 5'd1;

  // Alignment FSM with all outputs registered; pulses self-clear each cycle.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= SEARCH;
      com_cnt_q    <= '0;
      idx_q        <= '0;
      err_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      word_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      err_align_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      err_align_q  <= 1'b0;
      if (valid_in_8x32) begin
        case (state_q)
          SEARCH: begin
            if (is_com) begin
              if (com_cnt_d == LOCK_N) begin
                state_q   <= ACTIVE;
                com_cnt_q <= '0;
                idx_q     <= '0;
                err_cnt_q <= '0;
              end else begin
                com_cnt_q <= com_cnt_d[3:0];
              end
            end else begin
              com_cnt_q <= '0;
            end
          end
          ACTIVE: begin
            if (!is_com) begin
              byte_out_q   <= data_in_8x32;
              byte_valid_q <= 1'b1;
              byte_idx_q   <= idx_q;
              idx_q        <= idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                word_done_q  <= 1'b1;
                word_count_q <= word_count_q + 8'd1;
                err_cnt_q    <= '0;
              end
            end else if (idx_q != 2'd0) begin
              // COM inside a word: the demux holds a partial word to drop
              err_align_q <= 1'b1;
              discard_q   <= 1'b1;
              idx_q       <= '0;
              if (err_cnt_d == ERR_N) begin
                state_q   <= SEARCH;
                com_cnt_q <= '0;
                err_cnt_q <= '0;
              end else begin
                err_cnt_q <= err_cnt_d[3:0];
              end
            end
            // COM at idx 0 is idle fill between words
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_idx   = byte_idx_q;
  assign word_done  = word_done_q;
  assign discard    = discard_q;
  assign err_align  = err_align_q;
  assign active     = (state_q == ACTIVE);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_demux_8x32_ctrl.sv
// Randomized bench for demux_8x32_ctrl against a behavioural lock/word model.
module tb_demux_8x32_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam int COM_LOCK = 4;
  localparam int ERR_MAX  = 2;

  logic       clk_4f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in_8x32 = '0;
  logic       valid_in_8x32 = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [1:0] byte_idx;
  logic       word_done;
  logic       discard;
  logic       err_align;
  logic       active;
  logic [7:0] word_count;

  demux_8x32_ctrl #(.COM_CHAR(COM), .COM_LOCK(COM_LOCK), .ERR_MAX(ERR_MAX)) dut (
    .clk_4f(clk_4f), .reset_L(reset_L),
    .data_in_8x32(data_in_8x32), .valid_in_8x32(valid_in_8x32),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_idx(byte_idx),
    .word_done(word_done), .discard(discard), .err_align(err_align),
    .active(active), .word_count(word_count)
  );

  always #5 clk_4f = ~clk_4f;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit m_lock;
  int m_coms, m_pos, m_errs, m_words;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_coms = 0; m_pos = 0; m_errs = 0; m_words = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".bout"}, 32'(byte_out), 0);
    chk({tag, ".bv"},   32'(byte_valid), 0);
    chk({tag, ".idx"},  32'(byte_idx), 0);
    chk({tag, ".wd"},   32'(word_done), 0);
    chk({tag, ".dis"},  32'(discard), 0);
    chk({tag, ".err"},  32'(err_align), 0);
    chk({tag, ".act"},  32'(active), 0);
    chk({tag, ".wc"},   32'(word_count), 0);
  endtask

  // apply one byte slot and check the registered response one cycle later
  task automatic step(input logic v, input logic [7:0] d);
    bit e_bv, e_wd, e_dis, e_err;
    int e_idx;
    @(negedge clk_4f);
    valid_in_8x32 = v;
    data_in_8x32  = d;
    @(posedge clk_4f);
    #1;
    e_bv = 0; e_wd = 0; e_dis = 0; e_err = 0; e_idx = 0;
    if (v) begin
      if (!m_lock) begin
        if (d == COM) begin
          m_coms++;
          if (m_coms == COM_LOCK) begin
            m_lock = 1; m_coms = 0; m_pos = 0; m_errs = 0;
          end
        end else m_coms = 0;
      end else if (d != COM) begin
        e_bv = 1; e_idx = m_pos;
        if (m_pos == 3) begin
          e_wd = 1; m_words = (m_words + 1) % 256; m_errs = 0;
        end
        m_pos = (m_pos + 1) % 4;
      end else if (m_pos != 0) begin
        e_err = 1; e_dis = 1; m_pos = 0; m_errs++;
        if (m_errs == ERR_MAX) begin
          m_lock = 0; m_coms = 0; m_errs = 0;
        end
      end
    end
    chk("byte_valid", 32'(byte_valid), 32'(e_bv));
    chk("word_done",  32'(word_done),  32'(e_wd));
    chk("discard",    32'(discard),    32'(e_dis));
    chk("err_align",  32'(err_align),  32'(e_err));
    chk("active",     32'(active),     32'(m_lock));
    chk("word_count", 32'(word_count), 32'(m_words));
    if (e_bv) begin
      chk("byte_out", 32'(byte_out), 32'(d));
      chk("byte_idx", 32'(byte_idx), 32'(e_idx));
    end
  endtask

  task automatic coms(input int n);
    for (int i = 0; i < n; i++) step(1'b1, COM);
  endtask

  task automatic do_reset();
    @(posedge clk_4f);
    #3;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_4f);
      valid_in_8x32 = 1'($urandom);
      data_in_8x32  = 8'($urandom);
      @(posedge clk_4f);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    // 1: reset with random input, then no lock without COMs
    #2;
    model_reset();
    chk_zero("rst_init");
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h20 + i));

    // 2: lock, including an interrupted COM run
    coms(3); step(1'b1, 8'h12);
    chk("no_lock_after_12", 32'(active), 0);
    coms(3);
    chk("no_lock_3", 32'(active), 0);
    coms(1);
    chk("lock", 32'(active), 1);

    // 3: one word, then one word with stall gaps between bytes 1 and 2
    step(1'b1, 8'hA1); step(1'b1, 8'hA2); step(1'b1, 8'hA3); step(1'b1, 8'hA4);
    chk("wc_one", 32'(word_count), 1);
    step(1'b1, 8'hA1); step(1'b1, 8'hA2);
    step(1'b0, COM); step(1'b0, 8'h55); step(1'b0, COM);
    step(1'b1, 8'hA3); step(1'b1, 8'hA4);
    chk("wc_two", 32'(word_count), 2);

    // 4: mid-word COM, recovery at idx 0, idle COM between words
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, COM);
    chk("misalign_err", 32'(err_align), 1);
    step(1'b1, 8'h33);
    chk("after_err_idx", 32'(byte_idx), 0);
    step(1'b1, 8'h34); step(1'b1, 8'h35); step(1'b1, 8'h36);
    step(1'b1, COM);
    chk("idle_com_ok", 32'(err_align), 0);

    // 5: two errors without a completed word drop lock
    step(1'b1, 8'h11); step(1'b1, COM); step(1'b1, 8'h22); step(1'b1, COM);
    chk("lock_lost", 32'(active), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 8'hBB)));
    coms(COM_LOCK);

    // 6: 256 words from a fresh reset wrap the counter; reset mid-word at idx 2
    do_reset();
    coms(COM_LOCK);
    for (int w = 0; w < 256; w++)
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom_range(0, 8'hBB));
        step(1'b1, b);
      end
    chk("wrap", 32'(word_count), 0);
    step(1'b1, 8'h01); step(1'b1, 8'h02);
    step(1'b1, 8'h03); step(1'b1, 8'h04);
    step(1'b1, 8'h05); step(1'b1, 8'h06);
    do_reset();

    // random traffic: COM-heavy mix with gaps
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 35) b = COM;
      else b = 8'($urandom);
      step(1'($urandom_range(0, 99) < 85), b);
      if (i == 700) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
